job_loader: RTL and testbench

JOB_LOADER -- requirements
Module: job_loader

---
 rtl/shapool_pkg.sv | 10 +
 rtl/sync_edge.sv | 15 +
 rtl/job_loader.sv | 107 ++++++++++
 tb/tb_job_loader.sv | 145 ++++++++++++++
 4 files changed

// File: rtl/shapool_pkg.sv
// shapool_pkg: shared job loader widths and FSM state encodings.
package shapool_pkg;
  localparam int JOB_BITS_DEF   = 352;
  localparam int DAISY_BITS_DEF = 8;
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_FULL = 2'd2
  } state_t;
endpackage

// File: rtl/sync_edge.sv
// sync_edge: 2-flop synchronizer; EDGE=1 outputs a one-cycle rising-edge pulse, EDGE=0 the synced level.
module sync_edge #(
  parameter bit EDGE = 1'b0
) (
  input  logic hwclk,
  input  logic reset_in,
  input  logic i_d,
  output logic o_q
);
  logic [2:0] r_sh;
  always_ff @(posedge hwclk or posedge reset_in)
    if (reset_in) r_sh <= '0;
    else r_sh <= {r_sh[1:0], i_d};
  assign o_q = EDGE ? (r_sh[1] & ~r_sh[2]) : r_sh[1];
endmodule

// File: rtl/job_loader.sv
// job_loader: serial job + daisy-chain loader handing a full job frame to the core.
// Optional JOB_LOADER_PARITY_EN appends an even-parity bit to each job frame.
module job_loader import shapool_pkg::*; #(
  parameter int JOB_BITS   = JOB_BITS_DEF,
  parameter int DAISY_BITS = DAISY_BITS_DEF
) (
  input  logic                  hwclk,
  input  logic                  reset_in,
  input  logic                  data_clk,
  input  logic                  data_in,
  input  logic                  daisy_sel,
  input  logic                  daisy_in,
  output logic                  daisy_out,
  output logic [JOB_BITS-1:0]   job_data,
  output logic [DAISY_BITS-1:0] daisy_data,
  output logic                  job_valid,
  input  logic                  job_ready,
  output logic                  overrun,
  output logic                  parity_err
);
`ifdef JOB_LOADER_PARITY_EN
  localparam int FRAME = JOB_BITS + 1;
`else
  localparam int FRAME = JOB_BITS;
`endif
  localparam int CW = $clog2(FRAME + 1);
  logic w_tick, w_din, w_dsel, w_dain, w_jtick, w_dtick, w_last;
  state_t                r_state;
  logic [CW-1:0]         r_cnt;
  logic [JOB_BITS-1:0]   r_shift, r_job;
  logic [DAISY_BITS-1:0] r_daisy;
  logic                  r_dout, r_valid, r_ovr;
  sync_edge #(.EDGE(1'b1)) u_clk  (.hwclk(hwclk), .reset_in(reset_in), .i_d(data_clk),  .o_q(w_tick));
  sync_edge #(.EDGE(1'b0)) u_din  (.hwclk(hwclk), .reset_in(reset_in), .i_d(data_in),   .o_q(w_din));
  sync_edge #(.EDGE(1'b0)) u_dsel (.hwclk(hwclk), .reset_in(reset_in), .i_d(daisy_sel), .o_q(w_dsel));
  sync_edge #(.EDGE(1'b0)) u_dain (.hwclk(hwclk), .reset_in(reset_in), .i_d(daisy_in),  .o_q(w_dain));
  assign w_jtick = w_tick & ~w_dsel;
  assign w_dtick = w_tick & w_dsel;
  assign w_last  = r_cnt == CW'(FRAME - 1);
`ifdef JOB_LOADER_PARITY_EN
  logic r_par, r_perr;
  assign parity_err = r_perr;
`else
  assign parity_err = 1'b0;
`endif
  // Daisy ticks shift in every state; daisy_out carries the bit just pushed out of the MSB.
  always_ff @(posedge hwclk or posedge reset_in) begin
    if (reset_in) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_shift <= '0;
      r_job   <= '0;
      r_daisy <= '0;
      r_dout  <= 1'b0;
      r_valid <= 1'b0;
      r_ovr   <= 1'b0;
`ifdef JOB_LOADER_PARITY_EN
      r_par   <= 1'b0;
      r_perr  <= 1'b0;
`endif
    end else begin
      if (w_dtick) begin
        r_daisy <= {r_daisy[DAISY_BITS-2:0], w_dain};
        r_dout  <= r_daisy[DAISY_BITS-1];
      end
      case (r_state)
        ST_IDLE, ST_LOAD: if (w_jtick) begin
          r_cnt <= w_last ? '0 : r_cnt + 1'b1;
`ifdef JOB_LOADER_PARITY_EN
          r_par <= w_last ? 1'b0 : r_par ^ w_din;
          if (!w_last) begin
            r_shift <= {r_shift[JOB_BITS-2:0], w_din};
            r_state <= ST_LOAD;
          end else if (r_par ^ w_din) begin
            r_perr  <= 1'b1;
            r_state <= ST_IDLE;
          end else begin
            r_job   <= r_shift;
            r_valid <= 1'b1;
            r_state <= ST_FULL;
          end
`else
          r_shift <= {r_shift[JOB_BITS-2:0], w_din};
          if (w_last) begin
            r_job   <= {r_shift[JOB_BITS-2:0], w_din};
            r_valid <= 1'b1;
            r_state <= ST_FULL;
          end else r_state <= ST_LOAD;
`endif
        end
        ST_FULL: begin
          if (w_jtick) r_ovr <= 1'b1;
          if (job_ready) begin
            r_valid <= 1'b0;
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end
  assign daisy_out  = r_dout;
  assign job_data   = r_job;
  assign daisy_data = r_daisy;
  assign job_valid  = r_valid;
  assign overrun    = r_ovr;
endmodule

// File: tb/tb_job_loader.sv
// tb_job_loader: directed self-checking bench for job_loader (honours JOB_LOADER_PARITY_EN).
module tb_job_loader;
  import shapool_pkg::*;
  localparam int JB = 352;
  logic hwclk = 1'b0, reset_in = 1'b0, data_clk = 1'b0, data_in = 1'b0;
  logic daisy_sel = 1'b0, daisy_in = 1'b0, job_ready = 1'b0;
  logic daisy_out, job_valid, overrun, parity_err;
  logic [JB-1:0] job_data;
  logic [7:0] daisy_data;
  int n_chk = 0, n_fail = 0, n_rise = 0;
  logic pv = 1'b0;
  logic [JB-1:0] pat_a, pat_b, ones;
  logic [7:0] exp_out;
  job_loader dut (
    .hwclk(hwclk), .reset_in(reset_in), .data_clk(data_clk), .data_in(data_in),
    .daisy_sel(daisy_sel), .daisy_in(daisy_in), .daisy_out(daisy_out),
    .job_data(job_data), .daisy_data(daisy_data), .job_valid(job_valid),
    .job_ready(job_ready), .overrun(overrun), .parity_err(parity_err)
  );
  always #5 hwclk = ~hwclk;
  always @(posedge hwclk) begin
    if (job_valid && !pv) n_rise++;
    pv <= job_valid;
  end
  task automatic chk(input string tag, input logic [JB-1:0] obs, input logic [JB-1:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic tick(input logic s, input logic d);
    daisy_sel = s; data_in = d; daisy_in = d; data_clk = 1'b1;
    repeat (4) @(negedge hwclk);
    data_clk = 1'b0;
    repeat (4) @(negedge hwclk);
  endtask
  task automatic send_range(input logic [JB-1:0] v, input int hi, input int lo);
    for (int i = hi; i >= lo; i--) tick(1'b0, v[i]);
  endtask
  task automatic last_tick(input logic d);
    daisy_sel = 1'b0; data_in = d; data_clk = 1'b1;
    repeat (2) @(negedge hwclk);
    chk("valid_before_last_shift", job_valid, 1'b0);
    @(negedge hwclk);
    chk("valid_after_last_shift", job_valid, 1'b1);
    @(negedge hwclk);
    data_clk = 1'b0;
    repeat (4) @(negedge hwclk);
  endtask
  task automatic frame_from(input logic [JB-1:0] v, input int hi);
`ifdef JOB_LOADER_PARITY_EN
    send_range(v, hi, 0);
    last_tick(^v);
`else
    send_range(v, hi, 1);
    last_tick(v[0]);
`endif
  endtask
  task automatic accept();
    job_ready = 1'b1;
    @(negedge hwclk);
    job_ready = 1'b0;
    chk("valid_drop_after_accept", job_valid, 1'b0);
  endtask
  task automatic do_reset();
    reset_in = 1'b1;
    #2;
    chk("rst_valid", job_valid, 1'b0);
    chk("rst_overrun", overrun, 1'b0);
    chk("rst_daisy", daisy_data, 8'h00);
    chk("rst_daisy_out", daisy_out, 1'b0);
    @(negedge hwclk);
    reset_in = 1'b0;
    @(negedge hwclk);
  endtask
  initial begin
    pat_a = {44{8'hA5}};
    pat_b = {11{32'h0F1E2D3C}};
    ones = '1;
    exp_out = 8'h3C;
    @(negedge hwclk);
    do_reset();
    chk("rst_job_data", job_data, '0);
    chk("rst_parity_err", parity_err, 1'b0);
    chk("rst_state", dut.r_state, ST_IDLE);
    frame_from(pat_a, JB - 1);
    chk("job_data_a5", job_data, pat_a);
    tick(1'b0, 1'b1);
    chk("overrun_set", overrun, 1'b1);
    chk("overrun_job_data_held", job_data, pat_a);
    chk("overrun_valid_held", job_valid, 1'b1);
    for (int k = 7; k >= 0; k--) tick(1'b1, exp_out[k]);
    chk("daisy_data_3c", daisy_data, 8'h3C);
    for (int k = 7; k >= 0; k--) begin
      tick(1'b1, 1'b0);
      chk($sformatf("daisy_out_%0d", 7 - k), daisy_out, exp_out[k]);
    end
    chk("daisy_flushed", daisy_data, 8'h00);
    repeat (10) @(negedge hwclk);
    chk("valid_held_10", job_valid, 1'b1);
    accept();
    chk("state_idle_after_accept", dut.r_state, ST_IDLE);
    chk("job_data_hold_after_accept", job_data, pat_a);
    job_ready = 1'b1;
    repeat (3) @(negedge hwclk);
    job_ready = 1'b0;
    chk("ready_idle_no_effect", job_valid, 1'b0);
    chk("overrun_sticky", overrun, 1'b1);
    do_reset();
    send_range(ones, JB - 1, JB - 100);
    chk("partial_no_valid", job_valid, 1'b0);
    do_reset();
    chk("rst_state_mid", dut.r_state, ST_IDLE);
    n_rise = n_rise;
    begin
      int base;
      base = n_rise;
      send_range(pat_b, JB - 1, 200);
      tick(1'b1, 1'b1);
      tick(1'b1, 1'b0);
      chk("daisy_mid_frame", daisy_data, 8'h02);
      chk("state_load_mid", dut.r_state, ST_LOAD);
      frame_from(pat_b, 199);
      chk("job_data_post_reset", job_data, pat_b);
      repeat (4) @(negedge hwclk);
      chk("one_valid_pulse", n_rise - base, 1);
    end
    accept();
`ifdef JOB_LOADER_PARITY_EN
    send_range(pat_b, JB - 1, 0);
    tick(1'b0, ~^pat_b);
    chk("parity_err_set", parity_err, 1'b1);
    chk("parity_no_valid", job_valid, 1'b0);
    chk("parity_state_idle", dut.r_state, ST_IDLE);
    frame_from(pat_a, JB - 1);
    chk("parity_good_data", job_data, pat_a);
    accept();
`else
    chk("parity_err_tied", parity_err, 1'b0);
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
